// File: rtl/parity_stream_checker.sv
// rtl/parity_stream_checker.sv - frame parity checker over a valid/last beat stream with saturating error count
module parity_stream_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int ODD    = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic              in_par_i,
  input  logic              clr_cnt_i,
  output logic              busy_o,
  output logic              res_valid_o,
  output logic              res_err_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam logic             OddBit = (ODD != 0);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic             res_valid_q, res_valid_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Parity of everything seen in the open frame including this beat; acc is
  // ignored in IDLE so a stale value could never leak into a new frame.
  logic frame_par;
  logic frame_err;
  logic beat_last;

  assign frame_par = ((state_q == ST_ACCUM) ? acc_q : 1'b0) ^ (^in_data_i);
  assign frame_err = frame_par ^ in_par_i ^ OddBit;
  assign beat_last = in_valid_i & in_last_i;

  // State register; reset aborts any open frame without producing a result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: open a frame on a non-last beat, close it on the last beat
  always_comb begin
    state_d = state_q;
    if (in_valid_i) begin
      state_d = in_last_i ? ST_IDLE : ST_ACCUM;
    end
  end

  // Output decode: busy is simply the registered frame-open state
  always_comb begin
    busy_o = (state_q == ST_ACCUM);
  end

  // Datapath next-state: accumulator, result pulse/flag and saturating counter
  always_comb begin
    acc_d       = acc_q;
    res_valid_d = beat_last;
    res_err_d   = res_err_q;
    err_cnt_d   = err_cnt_q;
    if (in_valid_i) begin
      acc_d = in_last_i ? 1'b0 : frame_par;
    end
    if (beat_last) begin
      res_err_d = frame_err;
    end
    if (clr_cnt_i) begin
      err_cnt_d = '0;
    end else if (beat_last && frame_err && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + CntOne;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_err_o   = res_err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// tb/tb_parity_stream_checker.sv - randomized self-checking bench against a frame-level parity model
module tb_parity_stream_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_par;
  logic       clr_cnt;

  logic       busy_e, rv_e, re_e;
  logic [7:0] cnt_e;
  logic       busy_s, rv_s, re_s;
  logic [1:0] cnt_s;
  logic       busy_o, rv_o, re_o;
  logic [3:0] cnt_o;

  int checks;
  int failures;

  // Reference model state: beats of the open frame and expected outputs
  logic [7:0] frame_q[$];
  logic       exp_busy;
  logic       exp_rv;
  logic       exp_re_even;
  logic       exp_re_odd;
  int         exp_cnt_e;
  int         exp_cnt_s;
  int         exp_cnt_o;

  parity_stream_checker #(.DATA_W(8), .CNT_W(8), .ODD(0)) u_dut_even (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_par_i(in_par), .clr_cnt_i(clr_cnt),
    .busy_o(busy_e), .res_valid_o(rv_e), .res_err_o(re_e), .err_cnt_o(cnt_e)
  );

  parity_stream_checker #(.DATA_W(8), .CNT_W(2), .ODD(0)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_par_i(in_par), .clr_cnt_i(clr_cnt),
    .busy_o(busy_s), .res_valid_o(rv_s), .res_err_o(re_s), .err_cnt_o(cnt_s)
  );

  parity_stream_checker #(.DATA_W(8), .CNT_W(4), .ODD(1)) u_dut_odd (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_par_i(in_par), .clr_cnt_i(clr_cnt),
    .busy_o(busy_o), .res_valid_o(rv_o), .res_err_o(re_o), .err_cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // Apply one cycle of inputs, advance the model, then compare every output
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic p, input logic c, input logic r);
    int ones;
    bit err_even;
    bit err_odd;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; in_par = p; clr_cnt = c; rst = r;
    @(posedge clk);
    if (r) begin
      frame_q.delete();
      exp_rv = 0; exp_re_even = 0; exp_re_odd = 0;
      exp_cnt_e = 0; exp_cnt_s = 0; exp_cnt_o = 0;
    end else begin
      exp_rv = 0;
      err_even = 0;
      err_odd = 0;
      if (v) begin
        frame_q.push_back(d);
        if (l) begin
          ones = int'(p);
          foreach (frame_q[i]) ones += $countones(frame_q[i]);
          err_even = (ones % 2) != 0;
          err_odd  = (ones % 2) != 1;
          exp_rv = 1;
          exp_re_even = err_even;
          exp_re_odd  = err_odd;
          frame_q.delete();
        end
      end
      if (c) begin
        exp_cnt_e = 0; exp_cnt_s = 0; exp_cnt_o = 0;
      end else begin
        if (err_even) begin
          exp_cnt_e = sat_inc(exp_cnt_e, 255);
          exp_cnt_s = sat_inc(exp_cnt_s, 3);
        end
        if (err_odd) exp_cnt_o = sat_inc(exp_cnt_o, 15);
      end
    end
    exp_busy = (frame_q.size() > 0);
    #1;
    chk("busy_even", busy_e, exp_busy);
    chk("rv_even",   rv_e,   exp_rv);
    chk("err_even",  re_e,   exp_re_even);
    chk("cnt_even",  cnt_e,  exp_cnt_e);
    chk("busy_sat",  busy_s, exp_busy);
    chk("rv_sat",    rv_s,   exp_rv);
    chk("err_sat",   re_s,   exp_re_even);
    chk("cnt_sat",   cnt_s,  exp_cnt_s);
    chk("busy_odd",  busy_o, exp_busy);
    chk("rv_odd",    rv_o,   exp_rv);
    chk("err_odd",   re_o,   exp_re_odd);
    chk("cnt_odd",   cnt_o,  exp_cnt_o);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    in_valid = 0; in_data = 0; in_last = 0; in_par = 0; clr_cnt = 0; rst = 1;

    // Reset state
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("rst_busy", busy_e, 0);
    chk("rst_rv",   rv_e,   0);
    chk("rst_cnt",  cnt_e,  0);

    // Single-beat frames, good then bad parity
    step(1, 8'h01, 1, 1, 0, 0);
    chk("t1_rv", rv_e, 1);
    chk("t1_err", re_e, 0);
    chk("t1_cnt", cnt_e, 0);
    step(1, 8'h01, 1, 0, 0, 0);
    chk("t2_err", re_e, 1);
    chk("t2_cnt", cnt_e, 1);
    step(0, 8'h00, 0, 0, 0, 0);
    chk("t2_rv_low", rv_e, 0);
    chk("t2_err_held", re_e, 1);

    // Multi-beat frame with a gap
    step(1, 8'h41, 0, 0, 0, 0);
    chk("t3_busy1", busy_e, 1);
    step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    chk("t3_busy_gap", busy_e, 1);
    step(1, 8'h31, 0, 0, 0, 0);
    step(1, 8'hF1, 1, 0, 0, 0);
    chk("t3_busy_end", busy_e, 0);
    chk("t3_err", re_e, 0);

    // Saturation on the 2-bit counter, then clear racing a new error
    step(0, 8'h00, 0, 0, 1, 0);
    step(1, 8'h01, 1, 0, 0, 0); chk("t4_c1", cnt_s, 1);
    step(1, 8'h01, 1, 0, 0, 0); chk("t4_c2", cnt_s, 2);
    step(1, 8'h01, 1, 0, 0, 0); chk("t4_c3", cnt_s, 3);
    step(1, 8'h01, 1, 0, 0, 0); chk("t4_c4", cnt_s, 3);
    step(1, 8'h01, 1, 0, 0, 0); chk("t4_c5", cnt_s, 3);
    step(1, 8'h01, 1, 0, 1, 0);
    chk("t4_clr_cnt", cnt_s, 0);
    chk("t4_clr_err", re_s, 1);

    // Reset aborts an open frame
    step(1, 8'hFF, 0, 0, 0, 0);
    step(1, 8'h01, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("t5_busy", busy_e, 0);
    chk("t5_rv", rv_e, 0);
    step(1, 8'h03, 1, 0, 0, 0);
    chk("t5_err", re_e, 0);

    // Odd parity instance
    step(1, 8'hFF, 1, 1, 0, 0);
    chk("t6_odd_ok", re_o, 0);
    step(1, 8'h00, 1, 0, 0, 0);
    chk("t6_odd_bad", re_o, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 30),
           1'($urandom), ($urandom_range(0, 99) < 4), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
